// File: rtl/fixed_divider.sv
// Signed Q(W-FRAC).FRAC restoring divider, one quotient bit per clock, with sign fix-up and saturation.
// Optional FIXED_DIVIDER_ROUND_EN: extra guard iteration, result rounded half away from zero.
module fixed_divider #(
  parameter int W    = 24,
  parameter int FRAC = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] o_val,
  output logic         done,
  output logic         valid,
  output logic         dbz
);

`ifdef FIXED_DIVIDER_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int QW = W + FRAC + RND;
  localparam int CW = $clog2(QW + 1);
  localparam logic [QW-1:0] POS_MAX = {{(QW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [QW-1:0] NEG_MAX = POS_MAX + QW'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIX, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  babs_q, babs_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [QW-1:0] dvd_q, dvd_d, quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic [W-1:0]  val_q, val_d;
  logic          valid_q, valid_d, dbz_q, dbz_d;

  logic [W-1:0]  aabs, babs;
  logic [W:0]    rem_sh;
  logic [W-1:0]  rem_sub;
  logic          ge;
  logic [QW-1:0] mag;
  logic          ovf;

  // Magnitude of the most negative value is 2^(W-1), which still fits W unsigned bits.
  assign aabs    = a_q[W-1] ? (~a_q + W'(1)) : a_q;
  assign babs    = b_q[W-1] ? (~b_q + W'(1)) : b_q;
  assign rem_sh  = {rem_q, dvd_q[QW-1]};
  assign ge      = rem_sh >= {1'b0, babs_q};
  assign rem_sub = rem_sh[W-1:0] - babs_q;

`ifdef FIXED_DIVIDER_ROUND_EN
  assign mag = (quo_q >> 1) + QW'(quo_q[0]);
`else
  assign mag = quo_q;
`endif
  assign ovf = neg_q ? (mag > NEG_MAX) : (mag > POS_MAX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    babs_d  = babs_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    val_d   = val_q;
    valid_d = valid_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (b_q == '0) begin
          val_d   = '0;
          valid_d = 1'b0;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          babs_d  = babs;
          neg_d   = a_q[W-1] ^ b_q[W-1];
          dvd_d   = {aabs, {(FRAC+RND){1'b0}}};
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(QW);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d = ge ? rem_sub : rem_sh[W-1:0];
        quo_d = {quo_q[QW-2:0], ge};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (ovf) begin
          val_d   = neg_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          valid_d = 1'b0;
        end else begin
          val_d   = neg_q ? (~mag[W-1:0] + W'(1)) : mag[W-1:0];
          valid_d = 1'b1;
        end
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      babs_q  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      val_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      babs_q  <= babs_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      val_q   <= val_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_val = val_q;
  assign valid = valid_q;
  assign dbz   = dbz_q;
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_fixed_divider.sv
// Directed-vector bench for fixed_divider; expectations follow FIXED_DIVIDER_ROUND_EN when defined.
module tb_fixed_divider;

`ifdef FIXED_DIVIDER_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int LAT = 35 + RND;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [23:0] a = '0, b = '0;
  logic [23:0] o_val;
  logic        done, valid, dbz;

  int total = 0;
  int bad   = 0;

  fixed_divider dut (
    .CLK(CLK), .RST(RST), .start(start), .a(a), .b(b),
    .o_val(o_val), .done(done), .valid(valid), .dbz(dbz)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat is the cycle of the done pulse, -1 on timeout.
  task automatic run_op(input logic [23:0] av, input logic [23:0] bv, output int lat,
                        output logic [23:0] v, output logic vl, output logic dz);
    bit found = 0;
    @(negedge CLK);
    a = av; b = bv; start = 1'b1;
    lat = -1; v = 'x; vl = 1'bx; dz = 1'bx;
    for (int k = 1; k <= 100 && !found; k++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      if (done) begin
        found = 1; lat = k; v = o_val; vl = valid; dz = dbz;
      end
    end
    @(posedge CLK); #1;
  endtask

  typedef struct {
    string       tag;
    logic [23:0] av, bv, ev;
    logic        evl, edz;
    int          elat;
  } vec_t;

  initial begin
    vec_t        vt[$];
    int          lat, ndone;
    logic [23:0] v, first_v;
    logic        vl, dz;

    vt.push_back('{"div3_2",    24'h000300, 24'h000200, 24'h000180, 1'b1, 1'b0, LAT});
    vt.push_back('{"div2_3",    24'h000200, 24'h000300, RND ? 24'h0000AB : 24'h0000AA, 1'b1, 1'b0, LAT});
    vt.push_back('{"divm2_3",   24'hFFFE00, 24'h000300, RND ? 24'hFFFF55 : 24'hFFFF56, 1'b1, 1'b0, LAT});
    vt.push_back('{"dbz",       24'h000500, 24'h000000, 24'h000000, 1'b0, 1'b1, 2});
    vt.push_back('{"after_dbz", 24'h000500, 24'h000100, 24'h000500, 1'b1, 1'b0, LAT});
    vt.push_back('{"sat_pos",   24'h7FFF00, 24'h000001, 24'h7FFFFF, 1'b0, 1'b0, LAT});
    vt.push_back('{"sat_minneg",24'h800000, 24'hFFFF00, 24'h7FFFFF, 1'b0, 1'b0, LAT});
    vt.push_back('{"min_ok",    24'h800000, 24'h000100, 24'h800000, 1'b1, 1'b0, LAT});
    vt.push_back('{"tiny_zero", 24'hFFFFFF, 24'h7FFF00, 24'h000000, 1'b1, 1'b0, LAT});

    #1;
    chk("rst_oval",  32'(o_val), 32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_dbz",   32'(dbz),   32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;

    foreach (vt[i]) begin
      run_op(vt[i].av, vt[i].bv, lat, v, vl, dz);
      chk({vt[i].tag, "_lat"},   32'(lat), 32'(vt[i].elat));
      chk({vt[i].tag, "_oval"},  32'(v),   32'(vt[i].ev));
      chk({vt[i].tag, "_valid"}, 32'(vl),  32'(vt[i].evl));
      chk({vt[i].tag, "_dbz"},   32'(dz),  32'(vt[i].edz));
    end
    // Result held after the done cycle.
    chk("hold_oval", 32'(o_val), 32'h0);
    chk("hold_done", 32'(done),  32'h0);

    // start held high with a changing every cycle: one done in the window, first operands used.
    ndone = 0; first_v = '0;
    @(negedge CLK);
    b = 24'h000100; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 24'((i + 1) << 8);
      @(posedge CLK); #1;
      if (done) begin ndone++; first_v = o_val; end
      @(negedge CLK);
    end
    start = 1'b0;
    chk("held_ndone", 32'(ndone), 32'd1);
    chk("held_first", 32'(first_v), 32'h000100);
    lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge CLK); #1;
      if (done) lat = k;
    end
    chk("held_second_seen", 32'(lat >= 0), 32'd1);
    chk("held_second_oval", 32'(o_val), RND ? 32'h002600 : 32'h002500);
    @(posedge CLK); #1;

    // Reset in the middle of an operation.
    run_op(24'h000300, 24'h000200, lat, v, vl, dz);
    @(negedge CLK);
    a = 24'h000200; b = 24'h000300; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (9) @(posedge CLK);
    #1; RST = 1'b1;
    #1;
    chk("mid_rst_oval",  32'(o_val), 32'h0);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_dbz",   32'(dbz),   32'h0);
    chk("mid_rst_done",  32'(done),  32'h0);
    @(negedge CLK); RST = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    run_op(24'h000300, 24'h000200, lat, v, vl, dz);
    chk("fresh_lat",   32'(lat), 32'(LAT));
    chk("fresh_oval",  32'(v),   32'h000180);
    chk("fresh_valid", 32'(vl),  32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
